reduceron: RTL and testbench

- Minimal stack-based reduction core with a built-in 128-entry program ROM.
- Executes one instruction per clock, bump-allocates heap words, then halts.
- Exposes the top-of-stack result, the program counter (state), the heap pointer and a finish flag.
- Top-level compute block; the simulation harness watches `finish` and then reads the other outputs.

---
 rtl/reduceron.sv | 202 ++++++++++++++++++++
 tb/tb_reduceron.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reduceron.sv
// Minimal stack-based reduction core: one ROM instruction per clock, 18-bit operand stack,
// bump heap pointer, sticky finish on HALT or on any execution error.
module reduceron #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned LOOP_N      = 10,
  parameter logic [23:0] BOOT_WORD   = 24'h100000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [17:0] result,
  output logic [6:0]  state,
  output logic [14:0] heap,
  output logic        finish
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpPush  = 4'd1,
    OpAdd   = 4'd2,
    OpSub   = 4'd3,
    OpMul   = 4'd4,
    OpDup   = 4'd5,
    OpSwap  = 4'd6,
    OpPop   = 4'd7,
    OpOver  = 4'd8,
    OpJmp   = 4'd9,
    OpJz    = 4'd10,
    OpAlloc = 4'd11,
    OpHalt  = 4'd12
  } op_e;

  // ROM words are kept as {op, imm}; the two reserved bits between them are never decoded.
  function automatic logic [21:0] ins(input op_e op, input logic [17:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [21:0] rom_word(input logic [6:0] addr);
    case (addr)
      7'd0:    rom_word = {BOOT_WORD[23:20], BOOT_WORD[17:0]};
      7'd1:    rom_word = ins(OpPush, 18'(LOOP_N));
      7'd2:    rom_word = ins(OpDup, 18'd0);
      7'd3:    rom_word = ins(OpJz, 18'd12);
      7'd4:    rom_word = ins(OpSwap, 18'd0);
      7'd5:    rom_word = ins(OpOver, 18'd0);
      7'd6:    rom_word = ins(OpAdd, 18'd0);
      7'd7:    rom_word = ins(OpSwap, 18'd0);
      7'd8:    rom_word = ins(OpPush, 18'd1);
      7'd9:    rom_word = ins(OpSub, 18'd0);
      7'd10:   rom_word = ins(OpAlloc, 18'd2);
      7'd11:   rom_word = ins(OpJmp, 18'd2);
      7'd12:   rom_word = ins(OpPop, 18'd0);
      default: rom_word = ins(OpHalt, 18'd0);
    endcase
  endfunction

  logic [6:0]     pc_q, pc_d;
  logic [SpW-1:0] sp_q, sp_d;
  logic [14:0]    heap_q, heap_d;
  logic           finish_q, error_q;
  logic [17:0]    stk_q [STACK_DEPTH];

  logic [21:0]     instr;
  op_e             op;
  logic [17:0]     imm;
  logic [IdxW-1:0] push_idx, top_idx, sec_idx;
  logic [17:0]     a, b;
  logic [1:0]      need;
  logic            grow, bad_op, halt, fault, step;
  logic            push_en, top_en, sec_en;
  logic [17:0]     push_data, top_data, sec_data;

  // Indices are clamped so reads stay in range; any op that would misuse them faults first.
  always_comb begin
    push_idx = IdxW'(sp_q);
    top_idx  = (sp_q >= SpW'(1)) ? IdxW'(sp_q - SpW'(1)) : '0;
    sec_idx  = (sp_q >= SpW'(2)) ? IdxW'(sp_q - SpW'(2)) : '0;
    b        = stk_q[top_idx];
    a        = stk_q[sec_idx];
  end

  always_comb begin
    instr     = rom_word(pc_q);
    op        = op_e'(instr[21:18]);
    imm       = instr[17:0];
    pc_d      = pc_q + 7'd1;
    sp_d      = sp_q;
    heap_d    = heap_q;
    need      = 2'd0;
    grow      = 1'b0;
    bad_op    = 1'b0;
    halt      = 1'b0;
    push_en   = 1'b0;
    push_data = '0;
    top_en    = 1'b0;
    top_data  = '0;
    sec_en    = 1'b0;
    sec_data  = '0;
    case (op)
      OpNop: ;
      OpPush: begin
        grow      = 1'b1;
        push_en   = 1'b1;
        push_data = imm;
        sp_d      = sp_q + SpW'(1);
      end
      OpAdd: begin
        need     = 2'd2;
        sec_en   = 1'b1;
        sec_data = a + b;
        sp_d     = sp_q - SpW'(1);
      end
      OpSub: begin
        need     = 2'd2;
        sec_en   = 1'b1;
        sec_data = a - b;
        sp_d     = sp_q - SpW'(1);
      end
      OpMul: begin
        need     = 2'd2;
        sec_en   = 1'b1;
        sec_data = a * b;
        sp_d     = sp_q - SpW'(1);
      end
      OpDup: begin
        need      = 2'd1;
        grow      = 1'b1;
        push_en   = 1'b1;
        push_data = b;
        sp_d      = sp_q + SpW'(1);
      end
      OpSwap: begin
        need     = 2'd2;
        top_en   = 1'b1;
        top_data = a;
        sec_en   = 1'b1;
        sec_data = b;
      end
      OpPop: begin
        need = 2'd1;
        sp_d = sp_q - SpW'(1);
      end
      OpOver: begin
        need      = 2'd2;
        grow      = 1'b1;
        push_en   = 1'b1;
        push_data = a;
        sp_d      = sp_q + SpW'(1);
      end
      OpJmp: pc_d = imm[6:0];
      OpJz: begin
        need = 2'd1;
        sp_d = sp_q - SpW'(1);
        if (b == 18'd0) pc_d = imm[6:0];
      end
      OpAlloc: heap_d = heap_q + imm[14:0];
      OpHalt:  halt = 1'b1;
      default: bad_op = 1'b1;
    endcase
    fault = bad_op | (sp_q < SpW'(need)) | (grow & (sp_q == SpW'(STACK_DEPTH)));
    step  = ~finish_q & ~fault & ~halt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      sp_q     <= '0;
      heap_q   <= '0;
      finish_q <= 1'b0;
      error_q  <= 1'b0;
    end else if (!finish_q) begin
      if (fault) begin
        finish_q <= 1'b1;
        error_q  <= 1'b1;
      end else if (halt) begin
        finish_q <= 1'b1;
      end else begin
        pc_q   <= pc_d;
        sp_q   <= sp_d;
        heap_q <= heap_d;
      end
    end
  end

  // Stack storage needs no reset: entries at or above sp are never observed.
  always_ff @(posedge clock) begin
    if (!reset && step) begin
      if (push_en) stk_q[push_idx] <= push_data;
      if (top_en)  stk_q[top_idx]  <= top_data;
      if (sec_en)  stk_q[sec_idx]  <= sec_data;
    end
  end

  assign result = error_q            ? 18'h3FFFF :
                  (sp_q == SpW'(0))  ? 18'd0     : b;
  assign state  = pc_q;
  assign heap   = heap_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_reduceron.sv
// Scoreboard bench for reduceron: four instances (default, LOOP_N=0, LOOP_N=1000, underflow ROM)
// with per-instance resets; a monitor checks each rising finish against queued expectations.
module tb_reduceron;

  typedef struct {
    logic [17:0] r;
    logic [6:0]  s;
    logic [14:0] h;
    int          e;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst   [4];
  logic [17:0] res   [4];
  logic [6:0]  st    [4];
  logic [14:0] hp    [4];
  logic        fin   [4];
  bit          fin_prev [4];
  int          cnt   [4];

  exp_t q0[$], q1[$], q2[$], q3[$];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reduceron #(.STACK_DEPTH(16), .LOOP_N(10)) u0 (
    .clock(clock), .reset(rst[0]), .result(res[0]), .state(st[0]), .heap(hp[0]), .finish(fin[0])
  );
  reduceron #(.STACK_DEPTH(16), .LOOP_N(0)) u1 (
    .clock(clock), .reset(rst[1]), .result(res[1]), .state(st[1]), .heap(hp[1]), .finish(fin[1])
  );
  reduceron #(.STACK_DEPTH(16), .LOOP_N(1000)) u2 (
    .clock(clock), .reset(rst[2]), .result(res[2]), .state(st[2]), .heap(hp[2]), .finish(fin[2])
  );
  reduceron #(.STACK_DEPTH(16), .LOOP_N(10), .BOOT_WORD(24'h200000)) u3 (
    .clock(clock), .reset(rst[3]), .result(res[3]), .state(st[3]), .heap(hp[3]), .finish(fin[3])
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit pop_exp(input int id, output exp_t e);
    pop_exp = 1'b0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); pop_exp = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); pop_exp = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); pop_exp = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); pop_exp = 1'b1; end
    endcase
  endfunction

  // Edges elapsed since the last reset release, including the current one.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) cnt[i] <= rst[i] ? 0 : cnt[i] + 1;
  end

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (fin[i] === 1'b1 && !fin_prev[i]) begin
        exp_t e;
        if (pop_exp(i, e)) begin
          chk($sformatf("u%0d_result", i), res[i], e.r);
          chk($sformatf("u%0d_state", i), st[i], e.s);
          chk($sformatf("u%0d_heap", i), hp[i], e.h);
          chk($sformatf("u%0d_edges", i), cnt[i], e.e);
        end else begin
          checks++;
          failures++;
          $display("FAIL u%0d_unexpected_finish actual=1 required=0", i);
        end
      end
      fin_prev[i] <= (fin[i] === 1'b1);
    end
  end

  task automatic wait_fin(input int id, input int budget);
    int n;
    n = 0;
    while (fin[id] !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (fin[id] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL u%0d_finish_timeout actual=0 required=1", id);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, res[0], 0);
    chk({tag, "_state"}, st[0], 0);
    chk({tag, "_heap"}, hp[0], 0);
    chk({tag, "_finish"}, fin[0], 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk_zero("reset_held");
    end

    q0.push_back('{r: 18'd55, s: 7'd13, h: 15'd20, e: 106});
    q1.push_back('{r: 18'd0, s: 7'd13, h: 15'd0, e: 6});
    q2.push_back('{r: 18'd238356, s: 7'd13, h: 15'd2000, e: 10006});
    q3.push_back('{r: 18'h3FFFF, s: 7'd0, h: 15'd0, e: 1});
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    wait_fin(0, 200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("hold_result", res[0], 55);
      chk("hold_state", st[0], 13);
      chk("hold_heap", hp[0], 20);
      chk("hold_finish", fin[0], 1);
    end

    // Restart, then abort with a one-cycle reset on edge 50 and expect a clean rerun.
    rst[0] = 1'b1;
    repeat (2) @(negedge clock);
    rst[0] = 1'b0;
    repeat (49) @(negedge clock);
    chk("midrun_not_done", fin[0], 0);
    rst[0] = 1'b1;
    @(negedge clock);
    chk_zero("midrun_reset");
    q0.push_back('{r: 18'd55, s: 7'd13, h: 15'd20, e: 106});
    rst[0] = 1'b0;
    wait_fin(0, 200);

    chk("err_hold_result", res[3], 18'h3FFFF);
    chk("err_hold_finish", fin[3], 1);
    chk("err_hold_state", st[3], 0);

    wait_fin(2, 11000);
    repeat (3) @(negedge clock);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    chk("q3_left", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
